motor_array: RTL and testbench
==============================

# motor_array

Parametrised multi-channel DC motor controller, successor to the two-motor block. It drives CHANNELS H-bridges (INA/INB/PWM) from the 24-bit write channel, with ramped or immediate duty changes, safe reversal through zero, and active brake. Each channel has its own debounced encoder pulse counter. Counts are returned on request through the 24-bit read channel, and counter wraps are reported unsolicited.

## Interface
Parameters:
- CHANNELS, 4: number of motors, 1..16
- PWM_BITS, 11: duty width, 1..16
- CNT_BITS, 12: encoder counter width, 1..20
- DEB_DELAY, 50000: Debouncer DELAY (POSEDGE mode) per ppr input
- RAMP_DIV, 1000: clocks per ramp step, ≥1
- RAMP_STEP, 64: duty change per ramp step, ≥1

Ports:
- clk, in, 1: single system clock
- rst_n, in, 1: asynchronous active-low reset
- motor_ina, out, CHANNELS: H-bridge INA per channel
- motor_inb, out, CHANNELS: H-bridge INB per channel
- motor_pwm, out, CHANNELS: PWM per channel
- ppr_sence, in, CHANNELS: raw encoder inputs
- in_ctrl, in, 4: command tag
- in_data, in, 24: command word
- in_wr, in, 1: one-cycle write strobe
- out_ctrl, out, 4: reply tag
- out_data, out, 24: reply word
- out_wr, out, 1: one-cycle reply strobe

## Operation
- Command word layout: [23:20] channel, [19:18] opcode, [17] dir, [PWM_BITS-1:0] duty. Remaining bits are ignored.
- Opcode 00 SET: target := duty, tdir := dir. Output approaches target by ramping.
- Opcode 01 SET_NOW: current := duty, dir := dir immediately. Target := duty.
- Opcode 10 BRAKE: channel enters BRAKE. Current := 0, target := 0.
- Opcode 11 READ: reply {ch, zero-extended count} with out_ctrl = in_ctrl, then clear that counter.
- Channel ≥ CHANNELS: SET, SET_NOW and BRAKE are ignored. READ replies out_ctrl = 4'hE, out_data = {ch, 20'h0}.
- Per-channel FSM:
  - IDLE: current == target and dir == tdir.
  - RAMP: current ≠ target and dir == tdir.
  - REVERSE: dir ≠ tdir and current ≠ 0. Ramp toward 0; when current reaches 0, dir := tdir and go to RAMP or IDLE.
  - BRAKE: exits to RAMP/IDLE on SET and to IDLE on SET_NOW.
- If tdir ≠ dir while current == 0, dir flips on the next cycle.
- Ramp step occurs on a shared prescaler tick every RAMP_DIV clocks. current moves by RAMP_STEP toward its goal and is clamped at the goal, with no overshoot and no wrap.
- Outputs: active = (current ≠ 0).
  - ina = dir & active; inb = ~dir & active.
  - In BRAKE: ina = inb = 1, pwm = 1.
- PWM: a shared free-running PWM_BITS counter c. pwm = (c < current), registered.
- Encoder:
  - Debounced rising edge → count + 1.
  - Increment at all-ones: count := 0 and ovf_pending[ch] := 1. A repeat wrap while pending yields no extra report.
- READ with a simultaneous pulse on that channel: reply carries the pre-pulse value and the counter becomes 1.
- Reply arbitration: a READ reply always wins. Otherwise the lowest pending ovf channel is sent with out_ctrl = 4'hF and out_data = {ch, count field all-ones}, and its pending bit clears.
- At most one out_wr per cycle. Pending bits are never lost.

## Timing
- Reset state: all outputs 0. Counters, current, target, dir, prescaler, PWM counter and pending bits are all 0. All FSMs are IDLE.
- rst_n is asserted asynchronously, so outputs go low immediately, including mid-ramp and mid-brake. Release is synchronous to clk.
- Command is registered at the in_wr edge. current/state take effect the next cycle, and pin outputs follow one cycle later.
- READ reply: out_wr is high exactly 1 cycle after in_wr.
- in_wr may be asserted every cycle; each command is processed.
- Overflow report: earliest 1 cycle after the wrap, delayed while READ replies occupy the slot.
- Ramp from 0 to duty D takes ceil(D/RAMP_STEP) ticks.
- Debouncer latency is as defined by Debouncer with DEB_DELAY.

## Test plan
Bench parameters: RAMP_DIV=4, DEB_DELAY=5.

- SET ch0, dir 1, duty 200 → current steps 64/128/192/200 on consecutive ticks. ina[0]=1, inb[0]=0, and the pwm duty ratio matches.
- ch1 at 128 dir 0, then SET dir 1 duty 128 → ramps down to 0 with inb=1, then flips to ina=1 and ramps up. ina and inb are never both high.
- 10 encoder pulses on ch2, then READ tag 3 → out_wr 1 cycle later, out_ctrl=3, out_data=0x20000A. A second READ returns 0x200000.
- 4096 pulses on ch0 and ch3 wrapping in the same cycle as a READ of ch1 → the ch1 reply comes first, then 4'hF reports for ch0 and ch3 in order. Each report has data {ch, 20'h00FFF}.
- BRAKE ch0 at duty 500 → ina=inb=pwm=1 within 2 cycles. SET_NOW duty 0 → all 0.
- Assert rst_n low mid-ramp → outputs 0 immediately. After release, READ returns count 0. Invalid ch 9 READ → out_ctrl=4'hE.

Source files
------------

// File: rtl/motor_array.sv
// Multi-channel H-bridge motor controller: ramped or immediate duty, reversal
// through zero, active brake, debounced encoder counters and a shared reply port.
module motor_array #(
    parameter int CHANNELS  = 4,
    parameter int PWM_BITS  = 11,
    parameter int CNT_BITS  = 12,
    parameter int DEB_DELAY = 50000,
    parameter int RAMP_DIV  = 1000,
    parameter int RAMP_STEP = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [CHANNELS-1:0] motor_ina,
    output logic [CHANNELS-1:0] motor_inb,
    output logic [CHANNELS-1:0] motor_pwm,
    input  logic [CHANNELS-1:0] ppr_sence,
    input  logic [3:0]          in_ctrl,
    input  logic [23:0]         in_data,
    input  logic                in_wr,
    output logic [3:0]          out_ctrl,
    output logic [23:0]         out_data,
    output logic                out_wr
);
    typedef enum logic [1:0] {OP_SET, OP_SET_NOW, OP_BRAKE, OP_READ} op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_REVERSE, ST_BRAKE} state_t;

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEB_W = (DEB_DELAY > 1) ? $clog2(DEB_DELAY) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [DEB_W-1:0]    DEB_LAST = DEB_W'(DEB_DELAY - 1);
    localparam logic [31:0]         STEP32   = 32'(RAMP_STEP);
    localparam logic [PWM_BITS-1:0] STEP_P   = PWM_BITS'(RAMP_STEP);
    localparam logic [4:0]          CH_LIM   = 5'(CHANNELS);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    logic [3:0] w_in_ch;
    op_t        w_in_op;
    logic       w_ch_ok, w_rd, w_tick;
    logic       w_unused_bits;

    assign w_in_ch       = in_data[23:20];
    assign w_in_op       = op_t'(in_data[19:18]);
    assign w_ch_ok       = {1'b0, w_in_ch} < CH_LIM;
    assign w_rd          = in_wr && (w_in_op == OP_READ);
    assign w_unused_bits = ^in_data[16:0];

    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    assign w_tick = (r_pre == PRE_LAST);

    // NOTE: every flop resets asynchronously so the bridge pins drop the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre     <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pre     <= w_tick ? '0 : r_pre + PRE_W'(1);
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    logic                r_cmd_vld, r_cmd_dir;
    logic [3:0]          r_cmd_ch;
    op_t                 r_cmd_op;
    logic [PWM_BITS-1:0] r_cmd_duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_vld  <= 1'b0;
            r_cmd_ch   <= '0;
            r_cmd_op   <= OP_SET;
            r_cmd_dir  <= 1'b0;
            r_cmd_duty <= '0;
        end else begin
            r_cmd_vld  <= in_wr && w_ch_ok && (w_in_op != OP_READ);
            r_cmd_ch   <= w_in_ch;
            r_cmd_op   <= w_in_op;
            r_cmd_dir  <= in_data[17];
            r_cmd_duty <= in_data[PWM_BITS-1:0];
        end
    end

    logic [CNT_BITS-1:0] w_cnt [CHANNELS];
    logic [CHANNELS-1:0] w_wrap, w_clr, r_pend;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t              r_state, w_state_n;
        logic [PWM_BITS-1:0] r_cur, r_tgt, w_cur_n, w_tgt_n, w_goal, w_gap;
        logic                r_dir, r_tdir, w_dir_n, w_tdir_n, w_brk_n, w_hit;
        logic                r_ina, r_inb, r_pwm;
        logic [1:0]          r_sync;
        logic                r_stable, w_pulse, w_rd_hit;
        logic [DEB_W-1:0]    r_deb_cnt;
        logic [CNT_BITS-1:0] r_cnt;

        assign w_hit = r_cmd_vld && (r_cmd_ch == 4'(i));

        // NOTE: defaults first so no path through this block leaves a value unassigned (no latches).
        always_comb begin
            w_cur_n  = r_cur;
            w_tgt_n  = r_tgt;
            w_dir_n  = r_dir;
            w_tdir_n = r_tdir;
            w_brk_n  = (r_state == ST_BRAKE);
            w_goal   = (r_dir != r_tdir) ? '0 : r_tgt;
            w_gap    = (r_cur < w_goal) ? w_goal - r_cur : r_cur - w_goal;
            if (r_state != ST_BRAKE) begin
                if (r_dir != r_tdir && r_cur == '0) begin
                    w_dir_n = r_tdir;
                end else if (w_tick && r_cur != w_goal) begin
                    if (32'(w_gap) <= STEP32) w_cur_n = w_goal;
                    else if (r_cur < w_goal)  w_cur_n = r_cur + STEP_P;
                    else                      w_cur_n = r_cur - STEP_P;
                end
            end
            if (w_hit) begin
                case (r_cmd_op)
                    OP_SET: begin
                        w_tgt_n  = r_cmd_duty;
                        w_tdir_n = r_cmd_dir;
                        w_brk_n  = 1'b0;
                    end
                    OP_SET_NOW: begin
                        w_cur_n  = r_cmd_duty;
                        w_tgt_n  = r_cmd_duty;
                        w_dir_n  = r_cmd_dir;
                        w_tdir_n = r_cmd_dir;
                        w_brk_n  = 1'b0;
                    end
                    OP_BRAKE: begin
                        w_cur_n = '0;
                        w_tgt_n = '0;
                        w_brk_n = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (w_brk_n)                  w_state_n = ST_BRAKE;
            else if (w_dir_n != w_tdir_n) w_state_n = ST_REVERSE;
            else if (w_cur_n != w_tgt_n)  w_state_n = ST_RAMP;
            else                          w_state_n = ST_IDLE;
        end

        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_cur   <= '0;
                r_tgt   <= '0;
                r_dir   <= 1'b0;
                r_tdir  <= 1'b0;
            end else begin
                r_state <= w_state_n;
                r_cur   <= w_cur_n;
                r_tgt   <= w_tgt_n;
                r_dir   <= w_dir_n;
                r_tdir  <= w_tdir_n;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ina <= 1'b0;
                r_inb <= 1'b0;
                r_pwm <= 1'b0;
            end else if (r_state == ST_BRAKE) begin
                r_ina <= 1'b1;
                r_inb <= 1'b1;
                r_pwm <= 1'b1;
            end else begin
                r_ina <= r_dir && (r_cur != '0);
                r_inb <= !r_dir && (r_cur != '0);
                r_pwm <= r_pwm_cnt < r_cur;
            end
        end

        assign motor_ina[i] = r_ina;
        assign motor_inb[i] = r_inb;
        assign motor_pwm[i] = r_pwm;

        // A rising edge counts once the synchronised level has held for DEB_DELAY clocks.
        assign w_pulse  = r_sync[1] && !r_stable && (r_deb_cnt == DEB_LAST);
        assign w_rd_hit = w_rd && (w_in_ch == 4'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync    <= '0;
                r_stable  <= 1'b0;
                r_deb_cnt <= '0;
                r_cnt     <= '0;
            end else begin
                r_sync <= {r_sync[0], ppr_sence[i]};
                if (r_sync[1] == r_stable) begin
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == DEB_LAST) begin
                    r_stable  <= r_sync[1];
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                end
                if (w_rd_hit)     r_cnt <= CNT_BITS'(w_pulse);
                else if (w_pulse) r_cnt <= r_cnt + CNT_BITS'(1);
            end
        end

        assign w_wrap[i] = w_pulse && !w_rd_hit && (r_cnt == CNT_MAX);
        assign w_cnt[i]  = r_cnt;
    end

    logic [CNT_BITS-1:0] w_rd_cnt;
    logic [3:0]          w_ovf_ch;
    logic                w_ovf_any;

    always_comb begin
        w_rd_cnt  = '0;
        w_ovf_ch  = '0;
        w_ovf_any = |r_pend;
        for (int k = 0; k < CHANNELS; k++)
            if (w_in_ch == 4'(k)) w_rd_cnt = w_cnt[k];
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (r_pend[k]) w_ovf_ch = 4'(k);
        for (int k = 0; k < CHANNELS; k++)
            w_clr[k] = !w_rd && r_pend[k] && (w_ovf_ch == 4'(k));
    end

    // READ replies own the slot; overflow reports wait, and a fresh wrap re-arms its bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr   <= 1'b0;
            out_ctrl <= '0;
            out_data <= '0;
            r_pend   <= '0;
        end else begin
            out_wr <= w_rd || w_ovf_any;
            if (w_rd) begin
                out_ctrl <= w_ch_ok ? in_ctrl : 4'hE;
                out_data <= {w_in_ch, (w_ch_ok ? 20'(w_rd_cnt) : 20'h0)};
            end else if (w_ovf_any) begin
                out_ctrl <= 4'hF;
                out_data <= {w_ovf_ch, 20'(CNT_MAX)};
            end
            r_pend <= (r_pend & ~w_clr) | w_wrap;
        end
    end
endmodule

// File: tb/tb_motor_array.sv
// Self-checking bench for motor_array: scoreboarded replies plus motor pin,
// ramp and PWM checks against a small behavioural model.
module tb_motor_array;
    localparam logic [1:0] OP_SET = 2'd0, OP_SET_NOW = 2'd1, OP_BRAKE = 2'd2, OP_READ = 2'd3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  ina, inb, pwm, ppr = '0;
    logic [3:0]  in_ctrl = '0, out_ctrl;
    logic [23:0] in_data = '0, out_data;
    logic        in_wr = 1'b0, out_wr;

    motor_array #(.CHANNELS(4), .PWM_BITS(11), .CNT_BITS(12), .DEB_DELAY(5),
                  .RAMP_DIV(4), .RAMP_STEP(64)) dut (
        .clk(clk), .rst_n(rst_n), .motor_ina(ina), .motor_inb(inb), .motor_pwm(pwm),
        .ppr_sence(ppr), .in_ctrl(in_ctrl), .in_data(in_data), .in_wr(in_wr),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_wr(out_wr));

    always #5 clk = ~clk;

    typedef struct packed {logic [3:0] ctrl; logic [23:0] data;} reply_t;
    reply_t exp_q[$];
    reply_t mon_e;
    int checks = 0, errors = 0;
    int model_cnt[4] = '{0, 0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_reply got %0h/%0h expected none", out_ctrl, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("reply_ctrl", 32'(out_ctrl), 32'(mon_e.ctrl));
                check("reply_data", 32'(out_data), 32'(mon_e.data));
            end
        end
    end

    task automatic cmd(input logic [3:0] tag, input logic [3:0] ch, input logic [1:0] op,
                       input logic dir, input int duty);
        @(negedge clk);
        in_ctrl = tag;
        in_data = {ch, op, dir, 6'b0, 11'(duty)};
        in_wr   = 1'b1;
        @(negedge clk);
        in_wr   = 1'b0;
    endtask

    task automatic read_ch(input logic [3:0] tag, input int ch);
        if (ch < 4) begin
            exp_q.push_back({tag, 4'(ch), 20'(model_cnt[ch])});
            model_cnt[ch] = 0;
        end else begin
            exp_q.push_back({4'hE, 4'(ch), 20'h0});
        end
        cmd(tag, 4'(ch), OP_READ, 1'b0, 0);
        check("read_timing", 32'(out_wr), 1);
    endtask

    task automatic pulses(input logic [3:0] mask, input int n);
        repeat (n) begin
            ppr = ppr | mask;
            repeat (7) @(negedge clk);
            ppr = ppr & ~mask;
            repeat (7) @(negedge clk);
        end
        for (int c = 0; c < 4; c++) if (mask[c]) model_cnt[c] += n;
    endtask

    task automatic pwm_highs(input int ch, output int highs);
        highs = 0;
        repeat (2048) begin
            @(negedge clk);
            if (pwm[ch]) highs++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[$], times[$], exp_vals[$];
        logic [1:0] pins[$];
        int prev, v, highs, both;

        repeat (3) @(negedge clk);
        check("reset_ina", 32'(ina), 0);
        check("reset_inb", 32'(inb), 0);
        check("reset_pwm", 32'(pwm), 0);
        check("reset_out_wr", 32'(out_wr), 0);
        rst_n = 1'b1;

        // Ramp ch0 from 0 to 200, dir 1
        cmd(0, 0, OP_SET, 1'b1, 200);
        prev = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (int'(dut.g_ch[0].r_cur) != prev) begin
                prev = int'(dut.g_ch[0].r_cur);
                vals.push_back(prev);
                times.push_back(cyc);
            end
        end
        v = 0;
        while (v < 200) begin
            v = (v + 64 > 200) ? 200 : v + 64;
            exp_vals.push_back(v);
        end
        check("ramp_steps", vals.size(), exp_vals.size());
        for (int k = 0; k < exp_vals.size() && k < vals.size(); k++) begin
            check("ramp_value", vals[k], exp_vals[k]);
            if (k > 0) check("ramp_spacing", times[k] - times[k-1], 4);
        end
        check("ramp_ina", 32'(ina[0]), 1);
        check("ramp_inb", 32'(inb[0]), 0);
        pwm_highs(0, highs);
        check("ramp_pwm_ratio", highs, 200);

        // Reversal on ch1 through zero
        cmd(0, 1, OP_SET_NOW, 1'b0, 128);
        repeat (3) @(negedge clk);
        check("rev_start_inb", 32'(inb[1]), 1);
        check("rev_start_ina", 32'(ina[1]), 0);
        cmd(0, 1, OP_SET, 1'b1, 128);
        vals.delete(); exp_vals.delete();
        pins.delete();
        pins.push_back({ina[1], inb[1]});
        prev = 128;
        both = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (ina[1] && inb[1]) both++;
            if ({ina[1], inb[1]} != pins[pins.size()-1]) pins.push_back({ina[1], inb[1]});
            if (int'(dut.g_ch[1].r_cur) != prev) begin
                prev = int'(dut.g_ch[1].r_cur);
                vals.push_back(prev);
            end
        end
        v = 128;
        while (v > 0) begin v = (v > 64) ? v - 64 : 0; exp_vals.push_back(v); end
        while (v < 128) begin v = (v + 64 > 128) ? 128 : v + 64; exp_vals.push_back(v); end
        check("rev_cur_steps", vals.size(), exp_vals.size());
        for (int k = 0; k < exp_vals.size() && k < vals.size(); k++)
            check("rev_cur_value", vals[k], exp_vals[k]);
        check("rev_pin_phases", pins.size(), 3);
        if (pins.size() == 3) begin
            check("rev_phase0", 32'(pins[0]), 32'b01);
            check("rev_phase1", 32'(pins[1]), 32'b00);
            check("rev_phase2", 32'(pins[2]), 32'b10);
        end
        check("rev_never_both", both, 0);

        // Encoder count and clear-on-read on ch2
        pulses(4'b0100, 10);
        read_ch(4'd3, 2);
        read_ch(4'd3, 2);

        // Simultaneous wrap on ch0/ch3 while ch1 is read every cycle
        read_ch(4'd1, 0);
        read_ch(4'd1, 3);
        repeat (4) @(negedge clk);
        pulses(4'b1001, 4095);
        check("prewrap_quiet", exp_q.size(), 0);
        fork
            begin
                ppr = ppr | 4'b1001;
                repeat (7) @(negedge clk);
                ppr = ppr & ~4'b1001;
                repeat (7) @(negedge clk);
            end
            begin
                for (int j = 0; j < 12; j++) begin
                    @(negedge clk);
                    if (j > 0) check("burst_timing", 32'(out_wr), 1);
                    exp_q.push_back({4'h5, 4'd1, 20'(model_cnt[1])});
                    model_cnt[1] = 0;
                    in_ctrl = 4'h5;
                    in_data = {4'd1, OP_READ, 18'b0};
                    in_wr   = 1'b1;
                end
                exp_q.push_back({4'hF, 4'd0, 20'h00FFF});
                exp_q.push_back({4'hF, 4'd3, 20'h00FFF});
                @(negedge clk);
                in_wr = 1'b0;
                check("burst_timing", 32'(out_wr), 1);
            end
        join
        model_cnt[0] = (model_cnt[0] + 1) % 4096;
        model_cnt[3] = (model_cnt[3] + 1) % 4096;
        repeat (6) @(negedge clk);
        check("wrap_reports_drained", exp_q.size(), 0);
        read_ch(4'd2, 0);

        // Brake ch0 at 500, then release with SET_NOW 0
        cmd(0, 0, OP_SET_NOW, 1'b1, 500);
        repeat (3) @(negedge clk);
        cmd(0, 0, OP_BRAKE, 1'b0, 0);
        repeat (2) @(negedge clk);
        check("brake_pins", 32'({ina[0], inb[0], pwm[0]}), 32'b111);
        cmd(0, 0, OP_SET_NOW, 1'b1, 0);
        repeat (2) @(negedge clk);
        check("unbrake_pins", 32'({ina[0], inb[0], pwm[0]}), 32'b000);

        // Randomised encoder counts and PWM duties
        for (int r = 0; r < 4; r++) begin
            int ch, n;
            ch = $urandom_range(0, 3);
            n  = $urandom_range(1, 12);
            pulses(4'(1 << ch), n);
            read_ch(4'($urandom_range(0, 13)), ch);
        end
        for (int r = 0; r < 2; r++) begin
            int d;
            logic rdir;
            d    = $urandom_range(0, 2047);
            rdir = 1'($urandom_range(0, 1));
            cmd(0, 3, OP_SET_NOW, rdir, d);
            repeat (3) @(negedge clk);
            check("rand_ina", 32'(ina[3]), 32'(rdir && d != 0));
            check("rand_inb", 32'(inb[3]), 32'(!rdir && d != 0));
            pwm_highs(3, highs);
            check("rand_pwm_ratio", highs, d);
        end

        // Asynchronous reset mid-ramp
        pulses(4'b0100, 3);
        cmd(0, 2, OP_SET, 1'b1, 1000);
        repeat (20) @(negedge clk);
        check("midramp_ina", 32'(ina[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ina", 32'(ina), 0);
        check("async_reset_inb", 32'(inb), 0);
        check("async_reset_pwm", 32'(pwm), 0);
        for (int c = 0; c < 4; c++) model_cnt[c] = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_ch(4'd7, 2);
        read_ch(4'hA, 9);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
